regfile_dump: RTL and testbench

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump.sv | 124 ++++++++++++
 tb/tb_regfile_dump.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: walks the core register file from FIRST_REG to LAST_REG and
// streams each value out over a valid/ready port, accumulating a 32-bit sum.
//
// Handshake: out_valid is raised in SEND and out_data/out_idx are held
// stable until out_valid && out_ready is seen on a rising clk edge; that edge
// is the transfer. valid never depends on ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        dump request (IDLE only) / cancel (any non-IDLE state)
//   stall_req/stall_ack freeze request to the core and its acknowledge
//   rf_addr, rf_data    register-file read port (address from a flop)
//   out_valid/ready     output word handshake, out_data/out_idx payload
//   busy, done          not-IDLE flag, one-cycle completion pulse
//   sum                 mod-2^32 sum of the words of the last completed dump
module regfile_dump #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        stall_req,
  input  logic        stall_ack,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        busy,
  output logic        done,
  output logic [31:0] sum
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HALT = 3'd1,
    S_READ = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] acc;
  logic        launch;
  logic        capture;
  logic        xfer;
  logic        at_last;

  assign launch  = (state == S_IDLE) && start && !abort;
  assign capture = (state == S_READ) && stall_ack && !abort;
  // abort wins over a handshake that lands on the same edge
  assign xfer    = (state == S_SEND) && out_ready && !abort;
  // compared before the increment, so rf_addr never wraps past 31
  assign at_last = (rf_addr == 5'(LAST_REG));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start && !abort) state_next = S_HALT;
      S_HALT: begin
        if (abort)          state_next = S_IDLE;
        else if (stall_ack) state_next = S_READ;
      end
      S_READ: begin
        if (abort)          state_next = S_IDLE;
        else if (stall_ack) state_next = S_SEND;
        else                state_next = S_HALT;  // core resumed: re-halt, re-read same index
      end
      S_SEND: begin
        // stall_ack is irrelevant here: the word is already captured
        if (abort)          state_next = S_IDLE;
        else if (out_ready) state_next = at_last ? S_DONE : S_READ;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    out_valid = (state == S_SEND);
    stall_req = (state == S_HALT) || (state == S_READ) || (state == S_SEND);
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_addr  <= 5'd0;
      out_data <= 32'd0;
      out_idx  <= 5'd0;
      acc      <= 32'd0;
      sum      <= 32'd0;
    end else begin
      if (launch) begin
        rf_addr <= 5'(FIRST_REG);
        acc     <= 32'd0;
      end
      if (capture) begin
        out_data <= rf_data;
        out_idx  <= rf_addr;
      end
      if (xfer) begin
        acc <= acc + out_data;
        if (!at_last) rf_addr <= rf_addr + 5'd1;
      end
      // published only when a dump runs to completion
      if ((state == S_DONE) && !abort) sum <= acc;
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: default instance (x1..x31) plus a single-register
// instance (FIRST_REG=LAST_REG=31). A queue of expected {idx,data} words and a
// running sum form the model; one monitor compares the DUT against it.
module tb_regfile_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst_n, start, abort, stall_ack, out_ready;
  logic        stall_req, out_valid, busy, done;
  logic [4:0]  rf_addr, out_idx;
  logic [31:0] rf_data, out_data, sum;

  // single-register instance
  logic        rst2_n, start2, abort2, stall_ack2, out_ready2;
  logic        stall_req2, out_valid2, busy2, done2;
  logic [4:0]  rf_addr2, out_idx2;
  logic [31:0] rf_data2, out_data2, sum2;

  // register file contents: xN = N*0x11, x31 overridden in the second file
  assign rf_data  = 32'(rf_addr) * 32'h11;
  assign rf_data2 = (rf_addr2 == 5'd31) ? 32'hFFFF_FFFF : 32'(rf_addr2) * 32'h11;

  regfile_dump dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .stall_req(stall_req), .stall_ack(stall_ack),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done), .sum(sum)
  );

  regfile_dump #(.FIRST_REG(31), .LAST_REG(31)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .abort(abort2),
    .stall_req(stall_req2), .stall_ack(stall_ack2),
    .rf_addr(rf_addr2), .rf_data(rf_data2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_idx(out_idx2),
    .busy(busy2), .done(done2), .sum(sum2)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard: {idx[36:32], data[31:0]}
  logic [36:0] exp_q[$];
  logic [36:0] e;
  logic [31:0] model_acc;
  logic [31:0] exp_sum;
  logic        sum_pending;
  logic        prev_hold;
  logic [31:0] prev_data;
  logic [4:0]  prev_idx;
  int          done_cnt;
  int          word_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic queue_dump();
    exp_q.delete();
    for (int i = 1; i <= 31; i++) exp_q.push_back({5'(i), 32'(i) * 32'h11});
    model_acc = 32'd0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // counts cycles after the start edge up to and including the done cycle
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 300);
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done within 300 cycles");
    end
  endtask

  task automatic wait_word(input logic [4:0] idx);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_idx == idx) && n < 300);
    if (!(out_valid && out_idx == idx)) begin
      checks++; failures++;
      $display("FAIL word_timeout actual=none required=idx %0d", idx);
    end
  endtask

  // monitor: compares the default instance against the model every cycle
  initial begin
    sum_pending = 1'b0;
    prev_hold   = 1'b0;
    prev_data   = 32'd0;
    prev_idx    = 5'd0;
    done_cnt    = 0;
    word_cnt    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall_req", 32'(stall_req), 32'd0);
        check("rst_rf_addr",   32'(rf_addr),   32'd0);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_sum",       sum,            32'd0);
        sum_pending = 1'b0;
        prev_hold   = 1'b0;
      end else begin
        // core is held frozen exactly while a dump is reading/sending
        check("stall_req_rule", 32'(stall_req), 32'(busy && !done));
        if (sum_pending) begin
          check("sum_after_done", sum, exp_sum);
          sum_pending = 1'b0;
        end
        if (prev_hold && out_valid) begin
          check("hold_data", out_data, prev_data);
          check("hold_idx", 32'(out_idx), 32'(prev_idx));
        end
        prev_hold = out_valid && !out_ready && !abort;
        prev_data = out_data;
        prev_idx  = out_idx;
        if (out_valid && out_ready && !abort) begin
          word_cnt++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_word actual=idx %0d data 0x%08h required=no word", out_idx, out_data);
          end else begin
            e = exp_q.pop_front();
            check("word_idx",  32'(out_idx), 32'(e[36:32]));
            check("word_data", out_data,     e[31:0]);
            model_acc = model_acc + out_data;
          end
        end
        if (done) begin
          done_cnt++;
          check("words_left_at_done", 32'(exp_q.size()), 32'd0);
          if (!abort) begin
            sum_pending = 1'b1;
            exp_sum     = model_acc;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    checks++; failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int cyc, n, w0, d0, nw;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall_ack = 1'b1; out_ready = 1'b1;
    rst2_n = 1'b0; start2 = 1'b0; abort2 = 1'b0; stall_ack2 = 1'b1; out_ready2 = 1'b1;
    model_acc = 32'd0;
    exp_sum   = 32'd0;

    // reset state
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_sum",  sum,       32'd0);

    // full default dump, everything held ready
    queue_dump();
    w0 = word_cnt;
    pulse_start();
    wait_done(cyc);
    check("done_cycle", 32'(cyc), 32'd64);
    @(negedge clk);
    check("full_sum",   sum,                32'h0000_20F0);
    check("full_words", 32'(word_cnt - w0), 32'd31);
    check("full_idle",  32'(busy),          32'd0);

    // core slow to acknowledge the freeze
    queue_dump();
    @(posedge clk); #1 stall_ack = 1'b0;
    pulse_start();
    repeat (5) begin
      @(negedge clk);
      check("halt_stall_req", 32'(stall_req), 32'd1);
      check("halt_rf_addr",   32'(rf_addr),   32'd1);
      check("halt_no_valid",  32'(out_valid), 32'd0);
    end
    @(posedge clk); #1 stall_ack = 1'b1;
    // negedges: this HALT cycle, READ, then SEND (two edges after the rise)
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check("ack_to_valid", 32'(n), 32'd3);
    wait_done(cyc);
    @(negedge clk);

    // sink back-pressure on idx 7
    queue_dump();
    w0 = word_cnt;
    pulse_start();
    wait_word(5'd6);
    @(posedge clk); #1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  out_data,       32'h77);
      check("bp_idx",   32'(out_idx),   32'd7);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done(cyc);
    @(negedge clk);
    check("bp_words", 32'(word_cnt - w0), 32'd31);

    // freeze lost during READ of idx 4
    queue_dump();
    w0 = word_cnt;
    pulse_start();
    wait_word(5'd3);
    @(posedge clk); #1 stall_ack = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      check("reack_stall_req", 32'(stall_req), 32'd1);
      check("reack_no_valid",  32'(out_valid), 32'd0);
      check("reack_rf_addr",   32'(rf_addr),   32'd4);
    end
    @(posedge clk); #1 stall_ack = 1'b1;
    wait_done(cyc);
    @(negedge clk);
    check("reack_words", 32'(word_cnt - w0), 32'd31);

    // abort during SEND of idx 10, with out_ready high on the same edge
    queue_dump();
    pulse_start();
    wait_word(5'd9);
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    check("abort_in_send", 32'(out_idx), 32'd10);
    d0 = done_cnt;
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_stall_req", 32'(stall_req), 32'd0);
    check("abort_sum",       sum,            32'h0000_20F0);
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // start and abort together in IDLE
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", 32'(busy), 32'd0);

    // reset in the middle of a dump
    queue_dump();
    pulse_start();
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_stall_req", 32'(stall_req), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_rf_addr",   32'(rf_addr),   32'd0);
    check("arst_out_data",  out_data,       32'd0);
    check("arst_out_idx",   32'(out_idx),   32'd0);
    check("arst_sum",       sum,            32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_stays_idle", 32'(busy), 32'd0);

    // recovery: a complete dump after the reset
    queue_dump();
    pulse_start();
    wait_done(cyc);
    @(negedge clk);
    check("recover_sum", sum, 32'h0000_20F0);

    // single-register dump of x31
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    cyc = 0; nw = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (out_valid2) begin
        nw++;
        check("one_idx",  32'(out_idx2), 32'd31);
        check("one_data", out_data2,     32'hFFFF_FFFF);
      end
    end while (!done2 && cyc < 50);
    check("one_done_cycle", 32'(cyc), 32'd4);
    check("one_words",      32'(nw),  32'd1);
    @(negedge clk);
    check("one_sum", sum2, 32'hFFFF_FFFF);

    // asynchronous reset of the single-register instance mid-dump
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst2_n = 1'b0;
    #1;
    check("arst2_stall_req", 32'(stall_req2), 32'd0);
    check("arst2_out_valid", 32'(out_valid2), 32'd0);
    check("arst2_busy",      32'(busy2),      32'd0);
    check("arst2_done",      32'(done2),      32'd0);
    check("arst2_rf_addr",   32'(rf_addr2),   32'd0);
    check("arst2_out_data",  out_data2,       32'd0);
    check("arst2_out_idx",   32'(out_idx2),   32'd0);
    check("arst2_sum",       sum2,            32'd0);
    @(posedge clk); #1 rst2_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
